palette_lut: RTL and testbench
==============================

// Module: palette_lut
// PURPOSE
//  Programmable colour palette between sprite/background index logic and the VGA pins.
//  Maps a colour index to R/G/B through a writable, register-based palette with 1-cycle registered latency.
//  Forces black outside the active video region.
//  Provides a frame-synchronised screen-flash sequencer (black frames, then white frames) for shot feedback.
// PARAMETERS
//  IDX_W        4  colour index width; palette depth = 2**IDX_W entries
//  COLOR_W      4  bits per colour component (must be >= 4)
//  FLASH_FRAMES 2  frames spent in each flash phase (BLACK, then WHITE); >= 1
// PORTS
//  Clk          in   1          pixel clock
//  Reset        in   1          asynchronous, active-high reset
//  color_idx    in   IDX_W      palette index for current pixel
//  pix_valid    in   1          1 = active video pixel, 0 = blanking
//  wr_en        in   1          palette write strobe
//  wr_addr      in   IDX_W      entry to write
//  wr_data      in   3*COLOR_W  {R,G,B} written to entry
//  frame_tick   in   1          1-cycle pulse once per frame (start of vblank)
//  flash_req    in   1          1-cycle pulse requesting a flash sequence
//  VGA_R        out  COLOR_W    red output
//  VGA_G        out  COLOR_W    green output
//  VGA_B        out  COLOR_W    blue output
//  rgb_valid    out  1          pix_valid delayed 1 cycle
//  flash_active out  1          1 while in BLACK or WHITE
// BEHAVIOUR
//  Reset: VGA_R/G/B=0, rgb_valid=0, flash_active=0, FSM=IDLE, frame counter=0.
//  Reset also loads the palette defaults (4-bit {R,G,B}):
//   idx 0:000  1:000  2:FFF  3:660  4:8D0  5:050  6:0FB  7:520  8..max:000
//  For COLOR_W>4, each default nibble sits in the MSBs of its component; the LSBs are 0.
//  Lookup: RGB registered on each Clk edge; 1-cycle latency from color_idx/pix_valid to VGA_*.
//   pix_valid=0 -> registered output 000 (blanking), regardless of index or flash state.
//   pix_valid=1 -> palette[color_idx], unless overridden by flash (below).
//  Write: wr_en=1 updates palette[wr_addr] at the clock edge.
//   A lookup of the same address in the same cycle returns the OLD value (read-before-write).
//   The new value is visible from the next cycle's lookup.
//   Writes are accepted in every FSM state.
//  Flash FSM (one-hot or encoded; states IDLE, ARM, BLACK, WHITE):
//   IDLE : flash_req -> ARM. flash_req is ignored in every other state.
//   ARM  : waits for frame_tick, then -> BLACK with cnt=0. Flash always starts on a frame boundary.
//   BLACK: each frame_tick does cnt++. At the tick where cnt==FLASH_FRAMES-1 -> WHITE, cnt=0.
//   WHITE: same counting rule; at its final tick -> IDLE.
//   Simultaneous flash_req and frame_tick in IDLE -> ARM only; BLACK begins at the NEXT frame_tick.
//  Override, valid pixels only, applied in the same cycle as the lookup:
//   BLACK forces RGB=0.
//   WHITE forces all ones ({COLOR_W{1'b1}}) on each component.
//  flash_active is registered from the state and is 1 in BLACK and WHITE.
//  Reset mid-sequence -> IDLE immediately (asynchronous).
//   Palette contents return to defaults; writes made since the previous reset are lost.
//  frame_tick asserted for more than 1 cycle counts once per asserted cycle; the driver guarantees single-cycle pulses.
// TESTING
//  1. Reset, then pix_valid=1 with idx=4, 6, 2, 9 on consecutive cycles
//     -> one cycle later VGA = 8D0, 0FB, FFF, 000; rgb_valid follows pix_valid.
//  2. Write idx 3 <= A1C, then read idx 3 next cycle -> A1C.
//     Write idx 5 <= 123 while reading idx 5 in the same cycle -> 050 that cycle, 123 on the following read.
//  3. pix_valid=0 with idx=2 -> VGA=000, rgb_valid=0.
//     Toggle pix_valid every cycle -> outputs alternate FFF/000 with 1-cycle lag.
//  4. FLASH_FRAMES=2, flash_req, then 5 frame_ticks, with idx=4 held and pix_valid=1:
//     - ARM until tick 1: output 8D0.
//     - BLACK ticks 1-3: output 000.
//     - WHITE ticks 3-5: output FFF.
//     - After tick 5: IDLE, output 8D0.
//     flash_active high exactly between tick 1 and tick 5.
//  5. flash_req issued again during BLACK -> ignored; sequence length unchanged.
//     flash_req coincident with frame_tick in IDLE -> BLACK starts at the following tick.
//  6. Assert Reset during WHITE after writing idx 7 <= FFF
//     -> flash_active=0 and VGA=000 immediately; afterwards idx 7 reads 520.

Source files
------------

// File: rtl/palette_lut.sv
// Register-based colour palette with 1-cycle registered RGB output, blanking to black,
// and a frame-synchronised screen-flash sequencer (black frames, then white frames).
module palette_lut #(
   parameter int IDX_W        = 4,
   parameter int COLOR_W      = 4,
   parameter int FLASH_FRAMES = 2
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [IDX_W-1:0]       color_idx,
   input  logic                   pix_valid,
   input  logic                   wr_en,
   input  logic [IDX_W-1:0]       wr_addr,
   input  logic [3*COLOR_W-1:0]   wr_data,
   input  logic                   frame_tick,
   input  logic                   flash_req,
   output logic [COLOR_W-1:0]     VGA_R,
   output logic [COLOR_W-1:0]     VGA_G,
   output logic [COLOR_W-1:0]     VGA_B,
   output logic                   rgb_valid,
   output logic                   flash_active
);

   localparam int DEPTH = 2**IDX_W;
   localparam int RGB_W = 3*COLOR_W;
   localparam int CNT_W = $clog2(FLASH_FRAMES+1);

   typedef enum logic [1:0] {IDLE, ARM, BLACK, WHITE} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               last_frame;
   logic               force_black, force_white, in_flash;
   logic [RGB_W-1:0]   palette [DEPTH];

   // Wider components keep the 4-bit default nibble in their MSBs.
   function automatic logic [COLOR_W-1:0] scale_nibble(input logic [3:0] nib);
      return COLOR_W'(nib) << (COLOR_W-4);
   endfunction

   function automatic logic [RGB_W-1:0] default_entry(input int idx);
      logic [11:0] rgb4;
      case (idx)
         2:       rgb4 = 12'hFFF;
         3:       rgb4 = 12'h660;
         4:       rgb4 = 12'h8D0;
         5:       rgb4 = 12'h050;
         6:       rgb4 = 12'h0FB;
         7:       rgb4 = 12'h520;
         default: rgb4 = 12'h000;
      endcase
      return {scale_nibble(rgb4[11:8]), scale_nibble(rgb4[7:4]), scale_nibble(rgb4[3:0])};
   endfunction

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) palette[i] <= default_entry(i);
      end else if (wr_en) begin
         palette[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   assign last_frame = (cnt == CNT_W'(FLASH_FRAMES-1));

   // Flash phases advance only on frame ticks so the screen changes on frame boundaries.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
         IDLE:  if (flash_req) state_next = ARM;
         ARM:   if (frame_tick) begin
                   state_next = BLACK;
                   cnt_next   = '0;
                end
         BLACK: if (frame_tick) begin
                   if (last_frame) begin
                      state_next = WHITE;
                      cnt_next   = '0;
                   end else begin
                      cnt_next = cnt + CNT_W'(1);
                   end
                end
         WHITE: if (frame_tick) begin
                   if (last_frame) begin
                      state_next = IDLE;
                      cnt_next   = '0;
                   end else begin
                      cnt_next = cnt + CNT_W'(1);
                   end
                end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      force_black = (state == BLACK);
      force_white = (state == WHITE);
      in_flash    = force_black | force_white;
   end

   // Reading the palette array here sees the pre-write value, giving read-before-write.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         {VGA_R, VGA_G, VGA_B} <= '0;
         rgb_valid             <= 1'b0;
         flash_active          <= 1'b0;
      end else begin
         rgb_valid    <= pix_valid;
         flash_active <= in_flash;
         if (!pix_valid || force_black)
            {VGA_R, VGA_G, VGA_B} <= '0;
         else if (force_white)
            {VGA_R, VGA_G, VGA_B} <= '1;
         else
            {VGA_R, VGA_G, VGA_B} <= palette[color_idx];
      end
   end

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut: directed scenarios then random traffic,
// compared against a frame-counting behavioural model of palette and flash sequence.
module tb_palette_lut;

   localparam int IDX_W        = 4;
   localparam int COLOR_W      = 4;
   localparam int FLASH_FRAMES = 2;
   localparam int DEPTH        = 2**IDX_W;

   logic                 Clk = 1'b0;
   logic                 Reset = 1'b1;
   logic [IDX_W-1:0]     color_idx = '0;
   logic                 pix_valid = 1'b0;
   logic                 wr_en = 1'b0;
   logic [IDX_W-1:0]     wr_addr = '0;
   logic [3*COLOR_W-1:0] wr_data = '0;
   logic                 frame_tick = 1'b0;
   logic                 flash_req = 1'b0;
   logic [COLOR_W-1:0]   VGA_R, VGA_G, VGA_B;
   logic                 rgb_valid, flash_active;

   int vectors = 0;
   int miscompares = 0;

   // Model: mode 0 idle, 1 armed, 2 flashing; m_ticks counts frames since the flash began.
   logic [11:0] m_pal [DEPTH];
   int          m_mode;
   int          m_ticks;
   logic [11:0] exp_rgb;
   logic        exp_valid, exp_flash;

   palette_lut #(.IDX_W(IDX_W), .COLOR_W(COLOR_W), .FLASH_FRAMES(FLASH_FRAMES)) dut (
      .Clk(Clk), .Reset(Reset), .color_idx(color_idx), .pix_valid(pix_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_tick(frame_tick),
      .flash_req(flash_req), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .rgb_valid(rgb_valid), .flash_active(flash_active)
   );

   always #5 Clk = ~Clk;

   function automatic logic [11:0] default_colour(input int idx);
      case (idx)
         2: return 12'hFFF;
         3: return 12'h660;
         4: return 12'h8D0;
         5: return 12'h050;
         6: return 12'h0FB;
         7: return 12'h520;
         default: return 12'h000;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_pal[i] = default_colour(i);
      m_mode    = 0;
      m_ticks   = 0;
      exp_rgb   = 12'h000;
      exp_valid = 1'b0;
      exp_flash = 1'b0;
   endtask

   task automatic check_output(input string tag);
      vectors++;
      assert ({VGA_R, VGA_G, VGA_B} === exp_rgb) else begin
         miscompares++;
         $error("[TB] FAIL %s rgb: observed %03h expected %03h", tag, {VGA_R, VGA_G, VGA_B}, exp_rgb);
      end
      vectors++;
      assert (rgb_valid === exp_valid) else begin
         miscompares++;
         $error("[TB] FAIL %s rgb_valid: observed %b expected %b", tag, rgb_valid, exp_valid);
      end
      vectors++;
      assert (flash_active === exp_flash) else begin
         miscompares++;
         $error("[TB] FAIL %s flash_active: observed %b expected %b", tag, flash_active, exp_flash);
      end
   endtask

   // One clock of stimulus; expectations come from the model state before this edge.
   task automatic apply_stimulus(input string tag, input logic [3:0] idx, input logic valid,
                                 input logic we, input logic [3:0] waddr, input logic [11:0] wdata,
                                 input logic tick, input logic req);
      color_idx  = idx;
      pix_valid  = valid;
      wr_en      = we;
      wr_addr    = waddr;
      wr_data    = wdata;
      frame_tick = tick;
      flash_req  = req;
      exp_valid  = valid;
      exp_flash  = (m_mode == 2);
      if (!valid)
         exp_rgb = 12'h000;
      else if (m_mode == 2)
         exp_rgb = (m_ticks < FLASH_FRAMES) ? 12'h000 : 12'hFFF;
      else
         exp_rgb = m_pal[idx];
      if (we) m_pal[waddr] = wdata;
      case (m_mode)
         0: if (req) m_mode = 1;
         1: if (tick) begin
               m_mode  = 2;
               m_ticks = 0;
            end
         default: if (tick) begin
               m_ticks++;
               if (m_ticks == 2*FLASH_FRAMES) m_mode = 0;
            end
      endcase
      @(posedge Clk);
      #1;
      check_output(tag);
   endtask

   task automatic do_reset(input string tag);
      Reset = 1'b1;
      #2;
      model_reset();
      check_output(tag);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
   endtask

   task automatic pixel(input string tag, input logic [3:0] idx, input logic tick, input logic req);
      apply_stimulus(tag, idx, 1'b1, 1'b0, 4'h0, 12'h000, tick, req);
   endtask

   initial begin
      do_reset("reset");

      pixel("lookup4", 4'd4, 0, 0);
      pixel("lookup6", 4'd6, 0, 0);
      pixel("lookup2", 4'd2, 0, 0);
      pixel("lookup9", 4'd9, 0, 0);

      apply_stimulus("write3", 4'd0, 1'b0, 1'b1, 4'd3, 12'hA1C, 0, 0);
      pixel("read3", 4'd3, 0, 0);
      apply_stimulus("rbw5", 4'd5, 1'b1, 1'b1, 4'd5, 12'h123, 0, 0);
      pixel("read5", 4'd5, 0, 0);

      apply_stimulus("blank2", 4'd2, 1'b0, 1'b0, 4'd0, 12'h000, 0, 0);
      for (int i = 0; i < 6; i++)
         apply_stimulus("toggle", 4'd2, 1'((i + 1) % 2), 1'b0, 4'd0, 12'h000, 0, 0);

      pixel("flash_req", 4'd4, 0, 1);
      for (int t = 1; t <= 5; t++) begin
         for (int c = 0; c < 3; c++) pixel("flash_hold", 4'd4, 0, 0);
         pixel("flash_tick", 4'd4, 1, 0);
      end
      for (int c = 0; c < 3; c++) pixel("flash_after", 4'd4, 0, 0);

      pixel("req_tick_idle", 4'd4, 1, 1);
      pixel("armed", 4'd4, 0, 0);
      pixel("arm_tick", 4'd4, 1, 0);
      pixel("black_req", 4'd4, 0, 1);
      for (int t = 0; t < 5; t++) begin
         pixel("seq2_hold", 4'd4, 0, 0);
         pixel("seq2_tick", 4'd4, 1, 0);
      end

      apply_stimulus("write7", 4'd7, 1'b1, 1'b1, 4'd7, 12'hFFF, 0, 0);
      pixel("read7_new", 4'd7, 0, 1);
      pixel("arm_tick7", 4'd7, 1, 0);
      pixel("black_tick7", 4'd7, 1, 0);
      pixel("black_tick7b", 4'd7, 1, 0);
      pixel("white7", 4'd7, 0, 0);
      do_reset("reset_in_white");
      pixel("read7_default", 4'd7, 0, 0);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(199) == 0) begin
            do_reset("rand_reset");
         end else begin
            apply_stimulus("random", 4'($urandom_range(DEPTH-1)), ($urandom_range(3) != 0),
                           ($urandom_range(7) == 0), 4'($urandom_range(DEPTH-1)),
                           12'($urandom), ($urandom_range(11) == 0), ($urandom_range(15) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
